// File: rtl/regfile_debug_sequencer_if.sv
// Host command/response channel between a debug host and regfile_debug_sequencer.
// The host drives commands and accepts responses; the sequencer does the reverse.
interface regfile_debug_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_addr;
    logic [15:0] rsp_data;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_err
    );
endinterface

// File: rtl/regfile_debug_sequencer.sv
// Debug-host initiator for the LC-3 8x16 register file: read, write, dump and clear-all
// through the write port and read port 0, after obtaining ownership from the core arbiter.
module regfile_debug_sequencer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                            clk,
    input  logic                            reset,
    regfile_debug_sequencer_if.slave        host,
    output logic                            dbg_req,
    input  logic                            core_idle,
    output logic [15:0]                     rf_bus,
    output logic                            rf_we,
    output logic [2:0]                      rf_dr,
    output logic [2:0]                      rf_sr0,
    input  logic [15:0]                     rf_out0
);

    localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

    localparam logic [1:0] OpRead  = 2'b00;
    localparam logic [1:0] OpWrite = 2'b01;
    localparam logic [1:0] OpDump  = 2'b10;
    localparam logic [1:0] OpClear = 2'b11;

    typedef enum logic [2:0] {StIdle, StGrant, StWr, StRd, StClr, StRsp} state_e;

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [15:0]     data_q, data_d;
    logic [2:0]      idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      rsp_addr_q, rsp_addr_d;
    logic [15:0]     rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            op_q       <= OpRead;
            data_q     <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            rsp_addr_q <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            rsp_addr_q <= rsp_addr_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        data_d         = data_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        rsp_addr_d     = rsp_addr_q;
        rsp_data_d     = rsp_data_q;
        rsp_err_d      = rsp_err_q;
        host.cmd_ready = 1'b0;
        host.rsp_valid = 1'b0;
        dbg_req        = 1'b1;
        rf_we          = 1'b0;
        rf_dr          = '0;
        rf_bus         = '0;
        rf_sr0         = '0;

        unique case (state_q)
            StIdle: begin
                dbg_req        = 1'b0;
                host.cmd_ready = 1'b1;
                if (host.cmd_valid) begin
                    op_d    = host.cmd_op;
                    data_d  = host.cmd_data;
                    // Dump and clear always walk from register 0.
                    idx_d   = host.cmd_op[1] ? 3'd0 : host.cmd_addr;
                    cnt_d   = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                cnt_d = cnt_q + 1'b1;
                if (core_idle) begin
                    unique case (op_q)
                        OpWrite: state_d = StWr;
                        OpClear: state_d = StClr;
                        default: state_d = StRd;
                    endcase
                end else if (cnt_q == CntMax) begin
                    rsp_err_d  = 1'b1;
                    rsp_addr_d = idx_q;
                    rsp_data_d = '0;
                    state_d    = StRsp;
                end
            end
            StWr: begin
                rf_we      = 1'b1;
                rf_dr      = idx_q;
                rf_bus     = data_q;
                rsp_addr_d = idx_q;
                rsp_data_d = data_q;
                rsp_err_d  = 1'b0;
                state_d    = StRsp;
            end
            StRd: begin
                rf_sr0     = idx_q;
                rsp_addr_d = idx_q;
                rsp_data_d = rf_out0;
                rsp_err_d  = 1'b0;
                state_d    = StRsp;
            end
            StClr: begin
                rf_we = 1'b1;
                rf_dr = idx_q;
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    rsp_addr_d = 3'd7;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    state_d    = StRsp;
                end
            end
            StRsp: begin
                host.rsp_valid = 1'b1;
                if (host.rsp_ready) begin
                    if (op_q == OpDump && !rsp_err_q && idx_q != 3'd7) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = StRd;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign host.rsp_addr = rsp_addr_q;
    assign host.rsp_data = rsp_data_q;
    assign host.rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_regfile_debug_sequencer.sv
// Directed bench for regfile_debug_sequencer against a behavioural 8x16 register file.
module tb_regfile_debug_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rf_rst_n = 1'b0;
    logic        dbg_req;
    logic        core_idle = 1'b1;
    logic [15:0] rf_bus;
    logic        rf_we;
    logic [2:0]  rf_dr;
    logic [2:0]  rf_sr0;
    logic [15:0] rf_out0;
    logic [15:0] mem [8];

    regfile_debug_sequencer_if hif ();

    regfile_debug_sequencer #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .host      (hif.slave),
        .dbg_req   (dbg_req),
        .core_idle (core_idle),
        .rf_bus    (rf_bus),
        .rf_we     (rf_we),
        .rf_dr     (rf_dr),
        .rf_sr0    (rf_sr0),
        .rf_out0   (rf_out0)
    );

    always #5 clk = ~clk;

    // Register file model with its own reset, independent of the sequencer's.
    always @(posedge clk) begin
        if (!rf_rst_n) begin
            for (int i = 0; i < 8; i++) mem[i] <= 16'h0;
        end else if (rf_we) begin
            mem[rf_dr] <= rf_bus;
        end
    end
    assign rf_out0 = mem[rf_sr0];

    typedef struct {
        int          cyc;
        logic [2:0]  dr;
        logic [15:0] bus;
    } we_t;
    we_t we_log[$];
    int  cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (rf_we) we_log.push_back('{cyc: cyc, dr: rf_dr, bus: rf_bus});
    end

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  addr;
        logic [15:0] data;
        logic [2:0]  eaddr;
        logic [15:0] edata;
        logic        eerr;
    } vec_t;
    vec_t vecs[12];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [2:0] addr, input logic [15:0] data);
        int n = 0;
        while (!hif.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!hif.cmd_ready) check("issue_ready_wait", 32'(hif.cmd_ready), 32'd1);
        hif.cmd_valid = 1'b1;
        hif.cmd_op    = op;
        hif.cmd_addr  = addr;
        hif.cmd_data  = data;
        @(negedge clk);
        hif.cmd_valid = 1'b0;
    endtask

    // Waits for a response, holds it off for 'stall' cycles checking stability, then accepts it.
    task automatic get_rsp(input int stall, input logic [2:0] ea, input logic [15:0] ed,
                           input logic ee, input string tag);
        int n = 0;
        while (!hif.rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(hif.rsp_valid), 32'd1);
        if (!hif.rsp_valid) return;
        check({tag, "_addr"}, 32'(hif.rsp_addr), 32'(ea));
        check({tag, "_data"}, 32'(hif.rsp_data), 32'(ed));
        check({tag, "_err"}, 32'(hif.rsp_err), 32'(ee));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(hif.rsp_valid), 32'd1);
            check({tag, "_hold_addr"}, 32'(hif.rsp_addr), 32'(ea));
            check({tag, "_hold_data"}, 32'(hif.rsp_data), 32'(ed));
        end
        hif.rsp_ready = 1'b1;
        @(negedge clk);
        hif.rsp_ready = 1'b0;
    endtask

    initial begin
        int base;
        int n;
        hif.cmd_valid = 1'b0;
        hif.cmd_op    = 2'b00;
        hif.cmd_addr  = 3'd0;
        hif.cmd_data  = 16'h0;
        hif.rsp_ready = 1'b0;

        for (int i = 0; i < 8; i++)
            vecs[i] = '{op: 2'b01, addr: 3'(i), data: 16'h1000 + 16'(i),
                        eaddr: 3'(i), edata: 16'h1000 + 16'(i), eerr: 1'b0};
        vecs[8]  = '{op: 2'b00, addr: 3'd3, data: 16'hFFFF, eaddr: 3'd3, edata: 16'h1003, eerr: 1'b0};
        vecs[9]  = '{op: 2'b00, addr: 3'd7, data: 16'h0,    eaddr: 3'd7, edata: 16'h1007, eerr: 1'b0};
        vecs[10] = '{op: 2'b00, addr: 3'd0, data: 16'h0,    eaddr: 3'd0, edata: 16'h1000, eerr: 1'b0};
        vecs[11] = '{op: 2'b00, addr: 3'd5, data: 16'h0,    eaddr: 3'd5, edata: 16'h1005, eerr: 1'b0};

        // Reset
        repeat (2) @(negedge clk);
        reset    = 1'b1;
        rf_rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 32'(hif.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(hif.rsp_valid), 32'd0);
        check("rst_rsp_addr", 32'(hif.rsp_addr), 32'd0);
        check("rst_rsp_data", 32'(hif.rsp_data), 32'd0);
        check("rst_rsp_err", 32'(hif.rsp_err), 32'd0);
        check("rst_dbg_req", 32'(dbg_req), 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_rf_dr", 32'(rf_dr), 32'd0);
        check("rst_rf_sr0", 32'(rf_sr0), 32'd0);
        check("rst_rf_bus", 32'(rf_bus), 32'd0);

        // Single write
        base = we_log.size();
        issue(2'b01, 3'd3, 16'hBEEF);
        get_rsp(0, 3'd3, 16'hBEEF, 1'b0, "wr");
        check("wr_we_cycles", 32'(we_log.size() - base), 32'd1);
        if (we_log.size() > base) begin
            check("wr_dr", 32'(we_log[base].dr), 32'd3);
            check("wr_bus", 32'(we_log[base].bus), 32'hBEEF);
        end
        check("wr_mem3", 32'(mem[3]), 32'hBEEF);
        check("wr_idle", 32'(hif.cmd_ready), 32'd1);

        // Table: preload r0..r7 then read back
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].addr, vecs[i].data);
            get_rsp(0, vecs[i].eaddr, vecs[i].edata, vecs[i].eerr, $sformatf("vec%0d", i));
        end

        // Dump with alternating backpressure
        issue(2'b10, 3'd5, 16'h0);
        for (int i = 0; i < 8; i++)
            get_rsp((i % 2 == 0) ? 0 : 2, 3'(i), 16'h1000 + 16'(i), 1'b0,
                    $sformatf("dump%0d", i));
        check("dump_end_valid", 32'(hif.rsp_valid), 32'd0);
        check("dump_end_ready", 32'(hif.cmd_ready), 32'd1);

        // Reset in the middle of a dump, with response 4 pending
        issue(2'b10, 3'd0, 16'h0);
        for (int i = 0; i < 4; i++)
            get_rsp(0, 3'(i), 16'h1000 + 16'(i), 1'b0, $sformatf("mid%0d", i));
        n = 0;
        while (!hif.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_pend_addr", 32'(hif.rsp_addr), 32'd4);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("mid_rst_valid", 32'(hif.rsp_valid), 32'd0);
        check("mid_rst_dbg_req", 32'(dbg_req), 32'd0);
        check("mid_rst_ready", 32'(hif.cmd_ready), 32'd1);
        issue(2'b00, 3'd1, 16'h0);
        get_rsp(0, 3'd1, 16'h1001, 1'b0, "mid_rd1");

        // Clear-all then read
        base = we_log.size();
        issue(2'b11, 3'd4, 16'h1234);
        get_rsp(0, 3'd7, 16'h0, 1'b0, "clr");
        check("clr_we_cycles", 32'(we_log.size() - base), 32'd8);
        if (we_log.size() >= base + 8) begin
            for (int i = 0; i < 8; i++) begin
                check($sformatf("clr_dr%0d", i), 32'(we_log[base + i].dr), 32'(i));
                check($sformatf("clr_bus%0d", i), 32'(we_log[base + i].bus), 32'd0);
                check($sformatf("clr_cyc%0d", i), 32'(we_log[base + i].cyc - we_log[base].cyc),
                      32'(i));
            end
        end
        issue(2'b00, 3'd5, 16'h0);
        get_rsp(0, 3'd5, 16'h0, 1'b0, "clr_rd5");

        // Grant timeout: TIMEOUT=4 so the error appears 5 cycles after entering GRANT
        core_idle = 1'b0;
        base = we_log.size();
        issue(2'b00, 3'd2, 16'h0);
        check("to_dbg_req", 32'(dbg_req), 32'd1);
        n = 0;
        while (!hif.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("to_latency", 32'(n), 32'd5);
        get_rsp(0, 3'd2, 16'h0, 1'b1, "to");
        check("to_no_we", 32'(we_log.size() - base), 32'd0);
        check("to_idle", 32'(hif.cmd_ready), 32'd1);
        check("to_dbg_rel", 32'(dbg_req), 32'd0);
        core_idle = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
